// File: rtl/event_pairer_if.sv
// event_pairer_if: trigger-result inputs and event FIFO readout bundle for event_pairer
interface event_pairer_if #(
    parameter int FIFO_AW = 4
);
    logic               t_valid;
    logic [37:0]        t_in;
    logic               q_valid;
    logic [30:0]        q_in;
    logic [70:0]        ev_data;
    logic               ev_valid;
    logic               ev_ready;
    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_full;
    logic [15:0]        drop_cnt;

    modport master (
        output t_valid, t_in, q_valid, q_in, ev_ready,
        input  ev_data, ev_valid, fifo_count, fifo_full, drop_cnt
    );

    modport slave (
        input  t_valid, t_in, q_valid, q_in, ev_ready,
        output ev_data, ev_valid, fifo_count, fifo_full, drop_cnt
    );
endinterface

// File: rtl/event_pairer.sv
// event_pairer: pairs t/Q halves within MATCH_WINDOW into events, buffers them in a FWFT FIFO (EVENT_PAIRER_DROP_CNT_EN enables the drop counter)
module event_pairer #(
    parameter int MATCH_WINDOW = 16,
    parameter int FIFO_AW      = 4
) (
    input logic           clk,
    input logic           reset_n,
    event_pairer_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {IDLE, WAIT_Q, WAIT_T} state_t;

    state_t              state;
    logic [7:0]          timer;
    logic [37:0]         t_hold;
    logic [30:0]         q_hold;
    logic                emit_v;
    logic [70:0]         emit_d;
    logic [70:0]         mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [FIFO_AW:0]    count;
    logic                full;
    logic                pop;
    logic                push;

    assign full           = count == (FIFO_AW+1)'(DEPTH);
    assign bus.ev_valid   = count != '0;
    assign bus.ev_data    = bus.ev_valid ? mem[rd_ptr] : '0;
    assign bus.fifo_count = count;
    assign bus.fifo_full  = full;
    assign pop            = bus.ev_valid && bus.ev_ready;
    assign push           = emit_v && (!full || pop);

    // Pairing FSM: holds one half, registers the completed/partial event for the FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            timer  <= '0;
            t_hold <= '0;
            q_hold <= '0;
            emit_v <= 1'b0;
            emit_d <= '0;
        end else begin
            emit_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.t_valid && bus.q_valid) begin
                        emit_v <= 1'b1;
                        emit_d <= {2'b11, bus.t_in, bus.q_in};
                    end else if (bus.t_valid) begin
                        t_hold <= bus.t_in;
                        timer  <= '0;
                        state  <= WAIT_Q;
                    end else if (bus.q_valid) begin
                        q_hold <= bus.q_in;
                        timer  <= '0;
                        state  <= WAIT_T;
                    end
                end
                WAIT_Q: begin
                    if (bus.q_valid) begin
                        emit_v <= 1'b1;
                        emit_d <= {2'b11, t_hold, bus.q_in};
                        if (bus.t_valid) begin
                            t_hold <= bus.t_in;
                            timer  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bus.t_valid) begin
                        emit_v <= 1'b1;
                        emit_d <= {2'b10, t_hold, 31'b0};
                        t_hold <= bus.t_in;
                        timer  <= '0;
                    end else if (timer == 8'(MATCH_WINDOW - 1)) begin
                        emit_v <= 1'b1;
                        emit_d <= {2'b10, t_hold, 31'b0};
                        state  <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                WAIT_T: begin
                    if (bus.t_valid) begin
                        emit_v <= 1'b1;
                        emit_d <= {2'b11, bus.t_in, q_hold};
                        if (bus.q_valid) begin
                            q_hold <= bus.q_in;
                            timer  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bus.q_valid) begin
                        emit_v <= 1'b1;
                        emit_d <= {2'b01, 38'b0, q_hold};
                        q_hold <= bus.q_in;
                        timer  <= '0;
                    end else if (timer == 8'(MATCH_WINDOW - 1)) begin
                        emit_v <= 1'b1;
                        emit_d <= {2'b01, 38'b0, q_hold};
                        state  <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since ev_data is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= emit_d;
    end

    // FIFO pointers and occupancy; a pop in the same cycle makes room for a push when full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

`ifdef EVENT_PAIRER_DROP_CNT_EN
    logic [15:0] drop_q;

    // Saturating count of events discarded because the FIFO had no room
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else if (emit_v && !push && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_event_pairer.sv
// tb_event_pairer: directed + randomized check of event_pairer against a cycle-time reference model
module tb_event_pairer;
    localparam int MW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    event_pairer_if #(.FIFO_AW(AW)) bus ();

    event_pairer #(.MATCH_WINDOW(MW), .FIFO_AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO as a queue, pending half tracked by its arrival cycle
    logic [70:0] fq[$];
    bit          pend_v = 0;
    logic [70:0] pend_d = '0;
    int          hk = 0;
    logic [37:0] ht = '0;
    logic [30:0] hq = '0;
    int          birth = 0;
    int          cyc = 0;
    int          drops = 0;

    task automatic chk(string tag, logic [70:0] obs, logic [70:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_drop();
`ifdef EVENT_PAIRER_DROP_CNT_EN
        return 16'(drops);
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_clear();
        fq.delete();
        pend_v = 0;
        pend_d = '0;
        hk = 0;
        drops = 0;
    endtask

    task automatic model_edge(bit tv, logic [37:0] tin, bit qv, logic [30:0] qin, bit rdy);
        bit          nv = 0;
        logic [70:0] nd = '0;
        if (fq.size() > 0 && rdy) void'(fq.pop_front());
        if (pend_v) begin
            if (fq.size() < DEPTH) fq.push_back(pend_d);
            else if (drops < 65535) drops++;
        end
        cyc++;
        if (hk == 0) begin
            if (tv && qv) begin nv = 1; nd = {2'b11, tin, qin}; end
            else if (tv) begin hk = 1; ht = tin; birth = cyc; end
            else if (qv) begin hk = 2; hq = qin; birth = cyc; end
        end else if (hk == 1) begin
            if (qv) begin
                nv = 1; nd = {2'b11, ht, qin};
                if (tv) begin ht = tin; birth = cyc; end else hk = 0;
            end else if (tv) begin
                nv = 1; nd = {2'b10, ht, 31'b0}; ht = tin; birth = cyc;
            end else if (cyc - birth == MW) begin
                nv = 1; nd = {2'b10, ht, 31'b0}; hk = 0;
            end
        end else begin
            if (tv) begin
                nv = 1; nd = {2'b11, tin, hq};
                if (qv) begin hq = qin; birth = cyc; end else hk = 0;
            end else if (qv) begin
                nv = 1; nd = {2'b01, 38'b0, hq}; hq = qin; birth = cyc;
            end else if (cyc - birth == MW) begin
                nv = 1; nd = {2'b01, 38'b0, hq}; hk = 0;
            end
        end
        pend_v = nv;
        pend_d = nd;
    endtask

    task automatic check_all();
        chk("ev_valid", bus.ev_valid, fq.size() > 0);
        if (fq.size() > 0) chk("ev_data", bus.ev_data, fq[0]);
        chk("fifo_count", bus.fifo_count, fq.size());
        chk("fifo_full", bus.fifo_full, fq.size() == DEPTH);
        chk("drop_cnt", bus.drop_cnt, exp_drop());
    endtask

    task automatic step(bit tv, logic [37:0] tin, bit qv, logic [30:0] qin, bit rdy);
        bus.t_valid  = tv;
        bus.t_in     = tin;
        bus.q_valid  = qv;
        bus.q_in     = qin;
        bus.ev_ready = rdy;
        model_edge(tv, tin, qv, qin, rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, rdy);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_valid"}, bus.ev_valid, 0);
        chk({tag, "_data"}, bus.ev_data, 0);
        chk({tag, "_count"}, bus.fifo_count, 0);
        chk({tag, "_full"}, bus.fifo_full, 0);
        chk({tag, "_drop"}, bus.drop_cnt, 0);
    endtask

    initial begin
        logic [63:0] r;
        bus.t_valid  = 0;
        bus.t_in     = '0;
        bus.q_valid  = 0;
        bus.q_in     = '0;
        bus.ev_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        step(1, 38'h12_3456_789A, 1, 31'h0ABC_DEF0, 0);
        chk("pair_lat0", bus.ev_valid, 0);
        idle(1, 0);
        chk("pair_valid", bus.ev_valid, 1);
        chk("pair_data", bus.ev_data, {2'b11, 38'h12_3456_789A, 31'h0ABC_DEF0});
        chk("pair_count", bus.fifo_count, 1);
        idle(2, 1);

        step(1, 38'h1111, 0, '0, 0);
        idle(MW - 1, 0);
        step(0, '0, 1, 31'h2222, 0);
        step(1, 38'h3333, 0, '0, 0);
        idle(MW, 0);
        step(0, '0, 1, 31'h4444, 0);
        idle(MW + 2, 0);
        chk("win_count", bus.fifo_count, 3);
        chk("win_head", bus.ev_data, {2'b11, 38'h1111, 31'h2222});
        idle(4, 1);

        step(1, 38'h5555, 0, '0, 0);
        idle(2, 0);
        step(1, 38'h6666, 0, '0, 0);
        idle(1, 0);
        step(0, '0, 1, 31'h7777, 0);
        idle(3, 0);
        chk("b2b_count", bus.fifo_count, 2);
        chk("b2b_head", bus.ev_data, {2'b10, 38'h5555, 31'h0});
        idle(3, 1);

        for (int i = 0; i < 20; i++) step(1, 38'(i + 1), 1, 31'(i + 100), 0);
        idle(2, 0);
        chk("ovf_count", bus.fifo_count, 16);
        chk("ovf_full", bus.fifo_full, 1);
`ifdef EVENT_PAIRER_DROP_CNT_EN
        chk("ovf_drop", bus.drop_cnt, 4);
`else
        chk("ovf_drop", bus.drop_cnt, 0);
`endif
        chk("ovf_head", bus.ev_data, {2'b11, 38'd1, 31'd100});
        idle(18, 1);

        step(1, 38'h9999, 0, '0, 0);
        idle(1, 0);
        #3;
        reset_n = 1'b0;
        #2;
        model_clear();
        check_zero("rst_async");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle(20, 0);
        check_zero("rst_mid");

        for (int i = 0; i < 2000; i++) begin
            r = {$urandom(), $urandom()};
            step($urandom_range(0, 3) == 0, r[37:0], $urandom_range(0, 3) == 0, r[62:32],
                 (i / 250) % 2 == 0 ? $urandom_range(0, 5) == 0 : $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
